// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key front-end.
// Operation codes here drive the arithmetic unit's OP select directly.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    localparam int NUM_KEYS = 4;

    // Idle (not pressed) level of an active-low push-button.
    localparam logic KEY_RELEASED = 1'b1;

    // Key index maps one-to-one onto the operation code.
    function automatic op_t key_to_op(input logic [1:0] idx);
        return op_t'(idx);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single push-button conditioner: synchronizer chain, stability counter
// and stable-level flop. 'press' is high in the cycle a 1->0 change of the
// debounced level is accepted; releases produce no pulse.
module key_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 280000,
    parameter int CNT_W           = 19,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   synced;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];

    // Next-state: shift the raw key in, count cycles the synced level differs
    // from the stable one, and adopt it once it has held long enough.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], key_raw_n};
        cnt_d    = '0;
        stable_d = stable_q;
        accept   = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = synced;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset looks like a released, settled key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_q <= KEY_RELEASED;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign level = stable_q;
    assign press = accept && (synced != KEY_RELEASED);

endmodule

// File: rtl/key_op_selector.sv
// Calculator key front-end: debounces four active-low buttons and turns each
// accepted press into a registered op code plus a one-cycle op_valid strobe.
// Optional feature macro: KEY_OP_PRESS_COUNT_EN (accepted-press counter).
module key_op_selector
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 280000,
    parameter int CNT_W           = 19,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       CLK_28,
    input  logic       RST_N,
    input  logic [3:0] key_n,
    output logic [1:0] op,
    output logic       op_valid,
    output logic [3:0] key_level,
    output logic [7:0] press_count
);

    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] level;
    logic                any_press;
    logic [1:0]          sel_idx;
    op_t                 op_q, op_d;
    logic                op_valid_q, op_valid_d;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_deb (
            .clk       (CLK_28),
            .rst_n     (RST_N),
            .key_raw_n (key_n[k]),
            .level     (level[k]),
            .press     (press[k])
        );
    end

    // Priority encoder: scanning downward lets the lowest key index win when
    // several presses are accepted in the same cycle.
    always_comb begin
        any_press = 1'b0;
        sel_idx   = 2'd0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (press[k]) begin
                any_press = 1'b1;
                sel_idx   = 2'(k);
            end
        end
    end

    // Op register next-state: load on an accepted press, otherwise hold.
    always_comb begin
        op_d       = op_q;
        op_valid_d = any_press;
        if (any_press) begin
            op_d = key_to_op(sel_idx);
        end
    end

    // Op and strobe registers.
    always_ff @(posedge CLK_28 or negedge RST_N) begin
        if (!RST_N) begin
            op_q       <= OP_ADD;
            op_valid_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign op        = op_q;
    assign op_valid  = op_valid_q;
    assign key_level = level;

`ifdef KEY_OP_PRESS_COUNT_EN
    logic [7:0] count_q, count_d;

    // Count advances together with each op_valid strobe, wrapping at 255.
    always_comb begin
        count_d = count_q;
        if (op_valid_d) begin
            count_d = count_q + 8'd1;
        end
    end

    // Press counter register.
    always_ff @(posedge CLK_28 or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign press_count = count_q;
`else
    assign press_count = 8'd0;
`endif

endmodule

// File: tb/tb_key_op_selector.sv
// Bench for key_op_selector with a short debounce window. The reference model
// describes each key as "run of consecutive synced samples disagreeing with
// the accepted level"; a run of DC samples flips the level.
module tb_key_op_selector;

    localparam int DC = 4;
    localparam int SS = 2;
    localparam int CW = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [1:0] op;
    logic       op_valid;
    logic [3:0] key_level;
    logic [7:0] press_count;

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;

    // reference model state
    logic [3:0] m_delay[SS];
    logic [3:0] m_level;
    int         m_run[4];
    logic [1:0] m_op;
    logic       m_valid;
    logic [7:0] m_count;

    always #5 clk = ~clk;

    key_op_selector #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW),
        .SYNC_STAGES     (SS)
    ) dut (
        .CLK_28      (clk),
        .RST_N       (rst_n),
        .key_n       (key_n),
        .op          (op),
        .op_valid    (op_valid),
        .key_level   (key_level),
        .press_count (press_count)
    );

    function automatic void model_reset();
        for (int i = 0; i < SS; i++) m_delay[i] = 4'hF;
        for (int k = 0; k < 4; k++) m_run[k] = 0;
        m_level = 4'hF;
        m_op    = 2'd0;
        m_valid = 1'b0;
        m_count = 8'd0;
    endfunction

    // One clock edge of the model; raw is the key value seen at that edge.
    function automatic void model_edge(input logic [3:0] raw);
        logic [3:0] seen;
        int         winner;
        seen   = m_delay[SS-1];
        winner = -1;
        for (int k = 0; k < 4; k++) begin
            if (seen[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DC) begin
                    m_level[k] = seen[k];
                    m_run[k]   = 0;
                    if (seen[k] == 1'b0 && winner < 0) winner = k;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        for (int i = SS - 1; i > 0; i--) m_delay[i] = m_delay[i-1];
        m_delay[0] = raw;
        m_valid = (winner >= 0);
        if (m_valid) begin
            m_op = 2'(winner);
`ifdef KEY_OP_PRESS_COUNT_EN
            m_count = m_count + 8'd1;
`endif
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge(key_n);
        #1;
        chk("op", 32'(op), 32'(m_op));
        chk("op_valid", 32'(op_valid), 32'(m_valid));
        chk("key_level", 32'(key_level), 32'(m_level));
        chk("press_count", 32'(press_count), 32'(m_count));
        if (op_valid === 1'b1) strobes++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        // reset with all keys released
        rst_n = 1'b0;
        key_n = 4'hF;
        ticks(2);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_level", 32'(key_level), 32'hF);
        chk("rst_count", 32'(press_count), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // key1 held: single strobe at edge 6, op=1
        key_n   = 4'b1101;
        strobes = 0;
        ticks(5);
        chk("k1_no_early", 32'(strobes), 32'd0);
        tick();
        chk("k1_strobe", 32'(op_valid), 32'd1);
        chk("k1_op", 32'(op), 32'd1);
        ticks(12);
        chk("k1_one_strobe", 32'(strobes), 32'd1);
        chk("k1_level", 32'(key_level), 32'b1101);
        key_n = 4'hF;
        ticks(8);

        // key2 glitches of 3 cycles are rejected
        strobes = 0;
        for (int r = 0; r < 5; r++) begin
            key_n[2] = 1'b0;
            ticks(3);
            key_n[2] = 1'b1;
            ticks(2);
        end
        ticks(6);
        chk("glitch_strobes", 32'(strobes), 32'd0);
        chk("glitch_op", 32'(op), 32'd1);
        chk("glitch_level", 32'(key_level), 32'hF);

        // key3 and key0 together: key0 wins, then key3 alone
        strobes = 0;
        key_n   = 4'b0110;
        ticks(10);
        chk("dual_strobes", 32'(strobes), 32'd1);
        chk("dual_op", 32'(op), 32'd0);
        chk("dual_level", 32'(key_level), 32'b0110);
        key_n = 4'b1110;
        ticks(8);
        key_n = 4'b0110;
        ticks(8);
        chk("k3_op", 32'(op), 32'd3);
        key_n = 4'hF;
        ticks(8);

        // reset in the middle of key0's debounce
        strobes = 0;
        key_n   = 4'b1110;
        ticks(4);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_strobes", 32'(strobes), 32'd0);
        chk("mid_rst_op", 32'(op), 32'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        chk("post_rst_early", 32'(strobes), 32'd0);
        tick();
        chk("post_rst_strobe", 32'(op_valid), 32'd1);
        chk("post_rst_op", 32'(op), 32'd0);
        key_n = 4'hF;
        ticks(8);

        // random key patterns with random hold times
        for (int r = 0; r < 300; r++) begin
            key_n = 4'($urandom_range(0, 15));
            ticks($urandom_range(1, 8));
        end
        key_n = 4'hF;
        ticks(10);

        // 257 separate presses: counter wraps (or stays 0 without the feature)
        rst_n = 1'b0;
        model_reset();
        ticks(1);
        rst_n   = 1'b1;
        strobes = 0;
        for (int p = 0; p < 257; p++) begin
            key_n = 4'hF;
            key_n[$urandom_range(0, 3)] = 1'b0;
            ticks(7);
            key_n = 4'hF;
            ticks(7);
        end
        chk("many_strobes", 32'(strobes), 32'd257);
`ifdef KEY_OP_PRESS_COUNT_EN
        chk("many_count", 32'(press_count), 32'd1);
`else
        chk("many_count", 32'(press_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
